// File: rtl/vdma_lsram_fwft_fifo_pkg.sv
// Shared sizing helpers for the VDMA LSRAM FIFO: depth and level-width rules.
package vdma_fifo_pkg;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // LEVEL must represent 0..DEPTH inclusive, hence one bit more than the pointers.
  function automatic int level_width(input int addr_width);
    return addr_width + 1;
  endfunction

  function automatic int fifo_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

endpackage

// File: rtl/vdma_lsram_fwft_fifo_if.sv
// Push/pop/status bundle of the VDMA FIFO. OVERFLOW/UNDERFLOW exist only when
// VDMA_FIFO_ERR_FLAGS_EN is defined.
interface vdma_fifo_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 7
);
  // Push is taken when W_EN & ~FULL; pop is taken when R_EN & ~EMPTY, and R_EN
  // acknowledges the word currently on R_DATA. FLUSH overrides both.
  logic                  FLUSH;
  logic                  W_EN;
  logic [DATA_WIDTH-1:0] W_DATA;
  logic                  R_EN;
  logic [DATA_WIDTH-1:0] R_DATA;
  logic                  FULL;
  logic                  EMPTY;
  logic                  AFULL;
  logic                  AEMPTY;
  logic [ADDR_WIDTH:0]   LEVEL;
`ifdef VDMA_FIFO_ERR_FLAGS_EN
  logic                  OVERFLOW;
  logic                  UNDERFLOW;

  modport master (
    output FLUSH, W_EN, W_DATA, R_EN,
    input  R_DATA, FULL, EMPTY, AFULL, AEMPTY, LEVEL, OVERFLOW, UNDERFLOW
  );
  modport slave (
    input  FLUSH, W_EN, W_DATA, R_EN,
    output R_DATA, FULL, EMPTY, AFULL, AEMPTY, LEVEL, OVERFLOW, UNDERFLOW
  );
`else
  modport master (
    output FLUSH, W_EN, W_DATA, R_EN,
    input  R_DATA, FULL, EMPTY, AFULL, AEMPTY, LEVEL
  );
  modport slave (
    input  FLUSH, W_EN, W_DATA, R_EN,
    output R_DATA, FULL, EMPTY, AFULL, AEMPTY, LEVEL
  );
`endif
endinterface

// File: rtl/vdma_lsram_fwft_fifo_sdp.sv
// Simple dual-port LSRAM: unreset array, one-cycle registered read with enable.
// The read register doubles as the FIFO output register, so only it is reset.
module vdma_lsram_sdp
  import vdma_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);
  localparam int DEPTH = fifo_depth(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)     rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/vdma_lsram_fwft_fifo.sv
// First-word-fall-through FIFO over an LSRAM SDP array: pointers, level, flags,
// prefetch control. Optional sticky error flags under VDMA_FIFO_ERR_FLAGS_EN.
module vdma_lsram_fwft_fifo
  import vdma_fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 7,
  parameter int AFULL_THRESH  = 2**ADDR_WIDTH - 4,
  parameter int AEMPTY_THRESH = 4
) (
  input logic        CLK,
  input logic        RESET,
  vdma_fifo_if.slave bus
);
  localparam int                DEPTH     = fifo_depth(ADDR_WIDTH);
  localparam int                LVL_W     = level_width(ADDR_WIDTH);
  localparam logic [LVL_W-1:0]  DEPTH_L   = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0]  AFULL_L   = LVL_W'(AFULL_THRESH);
  localparam logic [LVL_W-1:0]  AEMPTY_L  = LVL_W'(AEMPTY_THRESH);
  localparam logic              AFULL_RST = (AFULL_THRESH == 0);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]      ram_cnt_q, ram_cnt_d;
  logic [LVL_W-1:0]      level_q, level_d;
  logic                  valid_q, valid_d;
  logic                  full_q, full_d;
  logic                  afull_q, afull_d;
  logic                  aempty_q, aempty_d;
  logic                  push, pop, prefetch;
  logic                  ram_we, ram_re;
  logic [DATA_WIDTH-1:0] rdata;

  always_comb begin
    push      = bus.W_EN & ~full_q;
    pop       = bus.R_EN & valid_q;
    // Refill the output register whenever it is empty or being consumed; ram_cnt
    // only counts completed writes, so the read never hits this cycle's write slot.
    prefetch  = (ram_cnt_q != '0) & (~valid_q | pop);
    ram_we    = push & ~bus.FLUSH;
    ram_re    = prefetch & ~bus.FLUSH;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    ram_cnt_d = ram_cnt_q;
    level_d   = level_q;
    valid_d   = valid_q;
    if (bus.FLUSH) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      ram_cnt_d = '0;
      level_d   = '0;
      valid_d   = 1'b0;
    end else begin
      wr_ptr_d  = wr_ptr_q + ADDR_WIDTH'(push);
      rd_ptr_d  = rd_ptr_q + ADDR_WIDTH'(prefetch);
      ram_cnt_d = ram_cnt_q + LVL_W'(push) - LVL_W'(prefetch);
      level_d   = level_q + LVL_W'(push) - LVL_W'(pop);
      valid_d   = prefetch | (valid_q & ~pop);
    end
    full_d   = (level_d == DEPTH_L);
    afull_d  = (level_d >= AFULL_L);
    aempty_d = (level_d <= AEMPTY_L);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      ram_cnt_q <= '0;
      level_q   <= '0;
      valid_q   <= 1'b0;
      full_q    <= 1'b0;
      afull_q   <= AFULL_RST;
      aempty_q  <= 1'b1;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      ram_cnt_q <= ram_cnt_d;
      level_q   <= level_d;
      valid_q   <= valid_d;
      full_q    <= full_d;
      afull_q   <= afull_d;
      aempty_q  <= aempty_d;
    end
  end

  vdma_lsram_sdp #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk_i   (CLK),
    .rst_i   (RESET),
    .we_i    (ram_we),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.W_DATA),
    .re_i    (ram_re),
    .raddr_i (rd_ptr_q),
    .rdata_o (rdata)
  );

  assign bus.R_DATA = rdata;
  assign bus.EMPTY  = ~valid_q;
  assign bus.FULL   = full_q;
  assign bus.AFULL  = afull_q;
  assign bus.AEMPTY = aempty_q;
  assign bus.LEVEL  = level_q;

`ifdef VDMA_FIFO_ERR_FLAGS_EN
  logic ovf_q, ovf_d;
  logic ufl_q, ufl_d;

  always_comb begin
    ovf_d = bus.FLUSH ? 1'b0 : (ovf_q | (bus.W_EN & full_q));
    ufl_d = bus.FLUSH ? 1'b0 : (ufl_q | (bus.R_EN & ~valid_q));
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ovf_q <= 1'b0;
      ufl_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      ufl_q <= ufl_d;
    end
  end

  assign bus.OVERFLOW  = ovf_q;
  assign bus.UNDERFLOW = ufl_q;
`endif
endmodule

// File: tb/tb_vdma_lsram_fwft_fifo.sv
// Directed bench for vdma_lsram_fwft_fifo at DEPTH=16, AFULL=12, AEMPTY=4.
// Error-flag checks are compiled in when VDMA_FIFO_ERR_FLAGS_EN is defined.
module tb_vdma_lsram_fwft_fifo;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int AF = 12;
  localparam int AE = 4;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_miss;
  logic [DW-1:0] exp_q[$];

  vdma_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  vdma_lsram_fwft_fifo #(
    .DATA_WIDTH    (DW),
    .ADDR_WIDTH    (AW),
    .AFULL_THRESH  (AF),
    .AEMPTY_THRESH (AE)
  ) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks: inputs change on negedge, outputs sampled on negedge
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push(input logic [DW-1:0] d);
    bus.W_EN   = 1'b1;
    bus.W_DATA = d;
    tick();
    bus.W_EN   = 1'b0;
    exp_q.push_back(d);
  endtask

  task automatic pop_check(input string tag);
    if (exp_q.size() == 0) begin
      check({tag, "_model_empty"}, 64'd1, 64'd0);
    end else begin
      check({tag, "_rdata"}, 64'(bus.R_DATA), 64'(exp_q[0]));
      check({tag, "_empty"}, 64'(bus.EMPTY), 64'd0);
      void'(exp_q.pop_front());
    end
    bus.R_EN = 1'b1;
    tick();
    bus.R_EN = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_level"},  64'(bus.LEVEL),  64'd0);
    check({tag, "_empty"},  64'(bus.EMPTY),  64'd1);
    check({tag, "_full"},   64'(bus.FULL),   64'd0);
    check({tag, "_afull"},  64'(bus.AFULL),  64'd0);
    check({tag, "_aempty"}, 64'(bus.AEMPTY), 64'd1);
  endtask

  initial begin
    n_vec      = 0;
    n_miss     = 0;
    rst        = 1'b1;
    bus.FLUSH  = 1'b0;
    bus.W_EN   = 1'b0;
    bus.W_DATA = '0;
    bus.R_EN   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // reset state
    check_idle("rst");
    check("rst_rdata", 64'(bus.R_DATA), 64'd0);
`ifdef VDMA_FIFO_ERR_FLAGS_EN
    check("rst_ovf", 64'(bus.OVERFLOW), 64'd0);
    check("rst_ufl", 64'(bus.UNDERFLOW), 64'd0);
`endif

    // single push: two-cycle fall-through
    push(32'hA5A5_0001);
    check("ft_empty_t",  64'(bus.EMPTY), 64'd1);
    check("ft_level_t",  64'(bus.LEVEL), 64'd1);
    tick();
    check("ft_empty_t1", 64'(bus.EMPTY), 64'd0);
    check("ft_rdata_t1", 64'(bus.R_DATA), 64'hA5A5_0001);
    check("ft_level_t1", 64'(bus.LEVEL), 64'd1);
    check("ft_aempty",   64'(bus.AEMPTY), 64'd1);
    pop_check("ft_pop");
    check_idle("ft_done");

    // fill to full, overflow, drain in order
    for (int i = 0; i < 16; i++) begin
      push(DW'(i));
      check("fill_level",  64'(bus.LEVEL),  64'(i + 1));
      check("fill_afull",  64'(bus.AFULL),  64'((i + 1) >= AF));
      check("fill_aempty", 64'(bus.AEMPTY), 64'((i + 1) <= AE));
      check("fill_full",   64'(bus.FULL),   64'((i + 1) == 16));
    end
    bus.W_EN   = 1'b1;
    bus.W_DATA = 32'hDEAD;
    tick();
    bus.W_EN   = 1'b0;
    check("ovf_level", 64'(bus.LEVEL), 64'd16);
    check("ovf_full",  64'(bus.FULL),  64'd1);
`ifdef VDMA_FIFO_ERR_FLAGS_EN
    check("ovf_flag", 64'(bus.OVERFLOW), 64'd1);
`endif
    for (int i = 0; i < 16; i++) begin
      pop_check("drain");
      check("drain_level", 64'(bus.LEVEL), 64'(15 - i));
    end
    check_idle("drain_done");
    bus.R_EN = 1'b1;
    tick();
    bus.R_EN = 1'b0;
    check("ufl_level", 64'(bus.LEVEL), 64'd0);
`ifdef VDMA_FIFO_ERR_FLAGS_EN
    check("ufl_flag", 64'(bus.UNDERFLOW), 64'd1);
`endif
    bus.FLUSH = 1'b1;
    tick();
    bus.FLUSH = 1'b0;
    check_idle("flush0");
`ifdef VDMA_FIFO_ERR_FLAGS_EN
    check("flush0_ovf", 64'(bus.OVERFLOW), 64'd0);
    check("flush0_ufl", 64'(bus.UNDERFLOW), 64'd0);
`endif

    // steady push+pop at LEVEL=8, pointers wrap many times
    for (int i = 0; i < 8; i++) push(DW'(32'h100 + i));
    check("ss_level0", 64'(bus.LEVEL), 64'd8);
    for (int i = 0; i < 100; i++) begin
      check("ss_rdata", 64'(bus.R_DATA), 64'(32'h100 + i));
      check("ss_empty", 64'(bus.EMPTY), 64'd0);
      bus.W_EN   = 1'b1;
      bus.W_DATA = DW'(32'h108 + i);
      bus.R_EN   = 1'b1;
      tick();
      void'(exp_q.pop_front());
      exp_q.push_back(DW'(32'h108 + i));
      check("ss_level", 64'(bus.LEVEL), 64'd8);
    end
    bus.W_EN = 1'b0;
    bus.R_EN = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("ss_tail", 64'(bus.R_DATA), 64'(32'h100 + 100 + i));
      pop_check("ss_drain");
    end
    check_idle("ss_done");

    // full with simultaneous push and pop
    for (int i = 0; i < 16; i++) push(DW'(32'h200 + i));
    check("fp_full", 64'(bus.FULL), 64'd1);
    check("fp_head", 64'(bus.R_DATA), 64'h200);
    bus.W_EN   = 1'b1;
    bus.W_DATA = 32'hBEEF;
    bus.R_EN   = 1'b1;
    tick();
    bus.W_EN = 1'b0;
    bus.R_EN = 1'b0;
    void'(exp_q.pop_front());
    check("fp_level", 64'(bus.LEVEL), 64'd15);
    check("fp_full0", 64'(bus.FULL),  64'd0);
    check("fp_next",  64'(bus.R_DATA), 64'h201);
    for (int i = 0; i < 15; i++) pop_check("fp_drain");
    check_idle("fp_done");

    // flush together with a push at LEVEL=6
    for (int i = 0; i < 6; i++) push(DW'(32'h300 + i));
    check("fl_level6", 64'(bus.LEVEL), 64'd6);
`ifdef VDMA_FIFO_ERR_FLAGS_EN
    check("fl_ovf_pre", 64'(bus.OVERFLOW), 64'd1);
`endif
    bus.FLUSH  = 1'b1;
    bus.W_EN   = 1'b1;
    bus.W_DATA = 32'h777;
    tick();
    bus.FLUSH = 1'b0;
    bus.W_EN  = 1'b0;
    exp_q.delete();
    check_idle("fl");
    check("fl_rdata_hold", 64'(bus.R_DATA), 64'h300);
`ifdef VDMA_FIFO_ERR_FLAGS_EN
    check("fl_ovf", 64'(bus.OVERFLOW), 64'd0);
`endif
    tick();
    tick();
    check("fl_absent", 64'(bus.EMPTY), 64'd1);
    push(32'h400);
    tick();
    check("fl_new_rdata", 64'(bus.R_DATA), 64'h400);
    check("fl_new_level", 64'(bus.LEVEL), 64'd1);
    pop_check("fl_pop");

    // asynchronous reset mid-burst at LEVEL=9
    for (int i = 0; i < 9; i++) push(DW'(32'h500 + i));
    check("ar_level9", 64'(bus.LEVEL), 64'd9);
    check("ar_aempty", 64'(bus.AEMPTY), 64'd0);
    bus.W_EN   = 1'b1;
    bus.W_DATA = 32'h5FF;
    bus.R_EN   = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check_idle("ar");
    check("ar_rdata", 64'(bus.R_DATA), 64'd0);
    @(negedge clk);
    bus.W_EN = 1'b0;
    bus.R_EN = 1'b0;
    rst      = 1'b0;
    exp_q.delete();
    tick();
    check_idle("ar_after");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
